// File: rtl/gcd_arbiter.sv
// gcd_arbiter: round-robin arbiter sharing one GCD engine among NREQ requesters.
// Optional per-requester grant counters are built when GCD_ARB_STATS_EN is defined.
module gcd_arbiter #(
    parameter int unsigned NREQ  = 4,
    parameter int unsigned STATW = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [32*NREQ-1:0]    req_data,
    output logic [NREQ-1:0]       req_ready,
    output logic [NREQ-1:0]       rsp_valid,
    output logic [16*NREQ-1:0]    rsp_data,
    input  logic [NREQ-1:0]       rsp_ready,
    output logic                  gcd_in_valid,
    output logic [31:0]           gcd_in_data,
    input  logic                  gcd_in_ready,
    input  logic                  gcd_out_valid,
    input  logic [15:0]           gcd_out_data,
`ifdef GCD_ARB_STATS_EN
    input  logic                  stat_clr,
    output logic [STATW*NREQ-1:0] stat_grants,
`endif
    output logic                  busy
);

    localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [PW:0] NreqW = (PW+1)'(NREQ);

    if (NREQ < 2 || NREQ > 8 || STATW < 1) begin : g_param_check
        $error("gcd_arbiter: unsupported NREQ/STATW");
    end

    typedef enum logic [1:0] {StIdle, StIssue, StWait} state_e;

    state_e             state_q, state_d;
    logic [PW-1:0]      rr_ptr_q, rr_ptr_d;
    logic [PW-1:0]      owner_q, owner_d;
    logic [31:0]        op_q, op_d;
    logic [NREQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [16*NREQ-1:0] rsp_data_q, rsp_data_d;

    logic [NREQ-1:0]    elig;
    logic [NREQ-1:0]    grant_oh;
    logic [PW-1:0]      grant_idx;
    logic               grant_any;
    logic [31:0]        grant_data;

    // A full response slot blocks new grants, so results are never overwritten.
    assign elig = req_valid & ~rsp_valid_q;

    always_comb begin
        logic [PW:0] idx;
        idx        = '0;
        grant_any  = 1'b0;
        grant_idx  = '0;
        grant_oh   = '0;
        grant_data = '0;
        for (int unsigned k = 0; k < NREQ; k++) begin
            idx = {1'b0, rr_ptr_q} + (PW+1)'(k);
            if (idx >= NreqW) idx = idx - NreqW;
            if (!grant_any && elig[idx[PW-1:0]]) begin
                grant_any = 1'b1;
                grant_idx = idx[PW-1:0];
            end
        end
        if (grant_any) grant_oh[grant_idx] = 1'b1;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (grant_oh[i]) grant_data = req_data[32*i +: 32];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= StIdle;
            rr_ptr_q    <= '0;
            owner_q     <= '0;
            op_q        <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rr_ptr_q    <= rr_ptr_d;
            owner_q     <= owner_d;
            op_q        <= op_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        rr_ptr_d    = rr_ptr_q;
        owner_d     = owner_q;
        op_d        = op_q;
        rsp_valid_d = rsp_valid_q & ~rsp_ready;
        rsp_data_d  = rsp_data_q;
        unique case (state_q)
            StIdle: begin
                if (grant_any) begin
                    op_d     = grant_data;
                    owner_d  = grant_idx;
                    rr_ptr_d = (grant_idx == PW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
                    state_d  = StIssue;
                end
            end
            StIssue: begin
                if (gcd_in_ready) state_d = StWait;
            end
            StWait: begin
                if (gcd_out_valid) begin
                    for (int unsigned i = 0; i < NREQ; i++) begin
                        if (owner_q == PW'(i)) begin
                            rsp_valid_d[i]          = 1'b1;
                            rsp_data_d[16*i +: 16] = gcd_out_data;
                        end
                    end
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // No grant is offered while reset is held.
    always_comb begin
        req_ready    = (state_q == StIdle && reset) ? grant_oh : '0;
        gcd_in_valid = (state_q == StIssue);
        gcd_in_data  = op_q;
        busy         = (state_q != StIdle);
        rsp_valid    = rsp_valid_q;
        rsp_data     = rsp_data_q;
    end

`ifdef GCD_ARB_STATS_EN
    logic [STATW*NREQ-1:0] stat_q, stat_d;

    // Clear wins over a same-cycle increment; counters saturate at all-ones.
    always_comb begin
        stat_d = stat_q;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (stat_clr) begin
                stat_d[STATW*i +: STATW] = '0;
            end else if (state_q == StIdle && grant_oh[i] &&
                         stat_q[STATW*i +: STATW] != {STATW{1'b1}}) begin
                stat_d[STATW*i +: STATW] = stat_q[STATW*i +: STATW] + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) stat_q <= '0;
        else        stat_q <= stat_d;
    end

    assign stat_grants = stat_q;
`endif

endmodule

// File: tb/tb_gcd_arbiter.sv
// tb_gcd_arbiter: scoreboard bench for gcd_arbiter driving a behavioural GCD engine model.
`timescale 1ns/1ps
module tb_gcd_arbiter;
    localparam int NREQ    = 4;
    localparam int STATW   = 4;
    localparam int ENG_LAT = 3;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [32*NREQ-1:0]    req_data;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       rsp_valid;
    logic [16*NREQ-1:0]    rsp_data;
    logic [NREQ-1:0]       rsp_ready;
    logic                  gcd_in_valid;
    logic [31:0]           gcd_in_data;
    logic                  gcd_in_ready;
    logic                  gcd_out_valid;
    logic [15:0]           gcd_out_data;
    logic                  busy;
`ifdef GCD_ARB_STATS_EN
    logic                  stat_clr;
    logic [STATW*NREQ-1:0] stat_grants;
`endif

    gcd_arbiter #(.NREQ(NREQ), .STATW(STATW)) u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_data      (req_data),
        .req_ready     (req_ready),
        .rsp_valid     (rsp_valid),
        .rsp_data      (rsp_data),
        .rsp_ready     (rsp_ready),
        .gcd_in_valid  (gcd_in_valid),
        .gcd_in_data   (gcd_in_data),
        .gcd_in_ready  (gcd_in_ready),
        .gcd_out_valid (gcd_out_valid),
        .gcd_out_data  (gcd_out_data),
`ifdef GCD_ARB_STATS_EN
        .stat_clr      (stat_clr),
        .stat_grants   (stat_grants),
`endif
        .busy          (busy)
    );

    always #5 clk = ~clk;

    int          vec_cnt = 0;
    int          err_cnt = 0;
    logic [15:0] exp_q  [NREQ][$];
    logic [31:0] pend_q [NREQ][$];
    int          grant_log[$];
    int          grant_cnt [NREQ];
    int          rsp_hi    [NREQ];
    logic [NREQ-1:0] acc_seen;
    logic        eng_busy;
    int          eng_cnt;
    logic [15:0] eng_res;
    logic        eng_take;
    logic [31:0] take_data;
    logic        stall;
    logic        rand_rsp;

    task automatic check_eq(string tag, logic [63:0] act, logic [63:0] exp);
        vec_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 'h%0h, want 'h%0h", tag, act, exp);
        end
    endtask

    function automatic logic [15:0] gcd16(logic [15:0] a, logic [15:0] b);
        logic [15:0] t;
        while (b != 16'd0) begin
            t = a % b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    task automatic send(int i, logic [15:0] x, logic [15:0] y);
        pend_q[i].push_back({x, y});
        exp_q[i].push_back(gcd16(x, y));
    endtask

    function automatic int outstanding();
        int n = 0;
        for (int i = 0; i < NREQ; i++) n += exp_q[i].size();
        return n;
    endfunction

    // One clock: observe at the falling edge, then update engine model and requesters.
    task automatic step();
        @(negedge clk);
        if (req_ready != '0) begin
            check_eq("req_ready_onehot", 64'($countones(req_ready)), 64'd1);
            check_eq("req_ready_elig", 64'(req_ready & ~(req_valid & ~rsp_valid)), 64'd0);
        end
        for (int i = 0; i < NREQ; i++) begin
            if (rsp_valid[i]) rsp_hi[i]++;
            if (req_valid[i] && req_ready[i]) begin
                acc_seen[i] = 1'b1;
                grant_log.push_back(i);
                grant_cnt[i]++;
            end
            if (rsp_valid[i] && rsp_ready[i]) begin
                if (exp_q[i].size() == 0)
                    check_eq($sformatf("rsp_unexpected%0d", i), 64'(rsp_valid[i]), 64'd0);
                else
                    check_eq($sformatf("rsp_data%0d", i), 64'(rsp_data[16*i +: 16]),
                             64'(exp_q[i].pop_front()));
            end
        end
        eng_take  = gcd_in_valid && gcd_in_ready;
        take_data = gcd_in_data;
        @(posedge clk);
        #1;
        gcd_out_valid = 1'b0;
        if (eng_busy) begin
            eng_cnt--;
            if (eng_cnt == 0) begin
                gcd_out_valid = 1'b1;
                gcd_out_data  = eng_res;
                eng_busy      = 1'b0;
            end
        end
        if (eng_take) begin
            eng_busy = 1'b1;
            eng_cnt  = ENG_LAT;
            eng_res  = gcd16(take_data[31:16], take_data[15:0]);
        end
        gcd_in_ready = !eng_busy && !stall;
        for (int i = 0; i < NREQ; i++) begin
            if (acc_seen[i] || !req_valid[i]) begin
                acc_seen[i] = 1'b0;
                if (pend_q[i].size() != 0) begin
                    req_valid[i]           = 1'b1;
                    req_data[32*i +: 32] = pend_q[i].pop_front();
                end else begin
                    req_valid[i] = 1'b0;
                end
            end
        end
        if (rand_rsp) rsp_ready = NREQ'($urandom);
    endtask

    task automatic drain(int budget, string tag);
        int n = 0;
        while (outstanding() != 0 && n < budget) begin
            step();
            n++;
        end
        check_eq({tag, "_drained"}, 64'(outstanding()), 64'd0);
    endtask

    task automatic clear_model();
        req_valid     = '0;
        req_data      = '0;
        gcd_out_valid = 1'b0;
        gcd_out_data  = '0;
        eng_busy      = 1'b0;
        eng_cnt       = 0;
        eng_res       = '0;
        acc_seen      = '0;
        for (int i = 0; i < NREQ; i++) begin
            exp_q[i].delete();
            pend_q[i].delete();
            grant_cnt[i] = 0;
            rsp_hi[i]    = 0;
        end
        grant_log.delete();
    endtask

    task automatic do_reset();
        reset        = 1'b0;
        rsp_ready    = '1;
        gcd_in_ready = 1'b1;
        stall        = 1'b0;
        rand_rsp     = 1'b0;
`ifdef GCD_ARB_STATS_EN
        stat_clr     = 1'b0;
`endif
        clear_model();
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(string tag);
        check_eq({tag, "_busy"}, 64'(busy), 64'd0);
        check_eq({tag, "_req_ready"}, 64'(req_ready), 64'd0);
        check_eq({tag, "_rsp_valid"}, 64'(rsp_valid), 64'd0);
        check_eq({tag, "_rsp_data"}, 64'(rsp_data), 64'd0);
        check_eq({tag, "_in_valid"}, 64'(gcd_in_valid), 64'd0);
        check_eq({tag, "_in_data"}, 64'(gcd_in_data), 64'd0);
    endtask

    initial begin
        int n;
        // Reset state, with a requester already valid to show req_ready is held low.
        reset        = 1'b0;
        rsp_ready    = '1;
        gcd_in_ready = 1'b1;
        stall        = 1'b0;
        rand_rsp     = 1'b0;
`ifdef GCD_ARB_STATS_EN
        stat_clr     = 1'b0;
`endif
        clear_model();
        req_valid = 4'b0001;
        #12;
        check_reset_outputs("reset");
        do_reset();

        // Single job {48,18} -> 6.
        send(0, 16'd48, 16'd18);
        drain(60, "single");
        check_eq("single_grants0", 64'(grant_cnt[0]), 64'd1);
        check_eq("single_rsp_pulse", 64'(rsp_hi[0]), 64'd1);

        // Round-robin from reset: order 0,1,2,3.
        do_reset();
        send(0, 16'd12, 16'd8);
        send(1, 16'd9, 16'd6);
        send(2, 16'd35, 16'd14);
        send(3, 16'd100, 16'd75);
        drain(200, "rr");
        check_eq("rr_count", 64'(grant_log.size()), 64'd4);
        for (int i = 0; i < NREQ; i++) begin
            if (i < grant_log.size())
                check_eq($sformatf("rr_order%0d", i), 64'(grant_log[i]), 64'(i));
        end

        // Backpressure on requester 1.
        do_reset();
        rsp_ready = 4'b1101;
        send(1, 16'd20, 16'd15);
        send(1, 16'd21, 16'd14);
        send(1, 16'd64, 16'd48);
        send(0, 16'd30, 16'd12);
        send(0, 16'd8, 16'd4);
        send(2, 16'd49, 16'd7);
        send(2, 16'd27, 16'd18);
        repeat (80) step();
        check_eq("bp_req0_done", 64'(exp_q[0].size()), 64'd0);
        check_eq("bp_req2_done", 64'(exp_q[2].size()), 64'd0);
        check_eq("bp_grants1", 64'(grant_cnt[1]), 64'd1);
        check_eq("bp_slot1_full", 64'(rsp_valid[1]), 64'd1);
        check_eq("bp_slot1_data", 64'(rsp_data[31:16]), 64'd5);
        rsp_ready = '1;
        drain(200, "bp");
        check_eq("bp_grants1_after", 64'(grant_cnt[1]), 64'd3);

        // Engine stall in ISSUE.
        do_reset();
        stall        = 1'b1;
        gcd_in_ready = 1'b0;
        send(3, 16'd462, 16'd1071);
        n = 0;
        while (!gcd_in_valid && n < 10) begin
            step();
            n++;
        end
        check_eq("stall_issue", 64'(gcd_in_valid), 64'd1);
        for (int c = 0; c < 5; c++) begin
            step();
            check_eq("stall_valid", 64'(gcd_in_valid), 64'd1);
            check_eq("stall_data", 64'(gcd_in_data), 64'({16'd462, 16'd1071}));
        end
        stall = 1'b0;
        step();
        check_eq("stall_still_issue", 64'(gcd_in_valid), 64'd1);
        step();
        check_eq("stall_advanced", 64'({busy, gcd_in_valid}), 64'b10);
        drain(60, "stall");

        // Asynchronous reset in the middle of WAIT.
        do_reset();
        send(1, 16'd1000, 16'd250);
        n = 0;
        while (!(busy && !gcd_in_valid) && n < 20) begin
            step();
            n++;
        end
        check_eq("abort_in_wait", 64'({busy, gcd_in_valid}), 64'b10);
        #2;
        reset = 1'b0;
        #1;
        check_reset_outputs("abort");
        clear_model();
        @(negedge clk);
        reset = 1'b1;
        repeat (20) step();
        check_eq("abort_no_rsp", 64'(rsp_valid), 64'd0);
        check_eq("abort_idle", 64'(busy), 64'd0);

        // Random mix with zero operands and random response backpressure.
        do_reset();
        rand_rsp = 1'b1;
        send(2, 16'd0, 16'd45);
        send(3, 16'd0, 16'd0);
        send(0, 16'd77, 16'd0);
        for (int k = 0; k < 14; k++)
            send(int'($urandom_range(0, NREQ - 1)), 16'($urandom_range(0, 300)),
                 16'($urandom_range(0, 300)));
        drain(3000, "random");
        rand_rsp  = 1'b0;
        rsp_ready = '1;

`ifdef GCD_ARB_STATS_EN
        // Saturating grant counters and synchronous clear.
        do_reset();
        check_eq("stat_reset", 64'(stat_grants), 64'd0);
        for (int k = 0; k < 5; k++) send(2, 16'(k + 3), 16'd6);
        drain(200, "stat5");
        check_eq("stat5_req2", 64'(stat_grants[11:8]), 64'd5);
        check_eq("stat5_req0", 64'(stat_grants[3:0]), 64'd0);
        for (int k = 0; k < 15; k++) send(2, 16'(k + 10), 16'd4);
        drain(500, "stat20");
        check_eq("stat20_sat", 64'(stat_grants[11:8]), 64'd15);
        stat_clr = 1'b1;
        step();
        stat_clr = 1'b0;
        check_eq("stat_clr", 64'(stat_grants), 64'd0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
